clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised bank of independently programmable synchronous clock dividers, the successor to the fixed divide-by-2 clock generator. It derives NUM_CH divided clocks from one source clock. Divide ratio and enable are reconfigured at runtime through a valid/ready port. Every change takes effect only at a period boundary, so outputs never glitch. It sits between the system clock input and downstream clock-consuming hierarchy.

## Interface
- NUM_CH, default 2: number of divider channels (1..16).
- DIV_W, default 8: divide-ratio width; maximum ratio 2^DIV_W-1.
- CH_W, derived as max(1,$clog2(NUM_CH)): channel-select width.

- clk_in  input  1  source clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when cfg_valid && cfg_ready.
- cfg_ch  input  CH_W  target channel.
- cfg_div  input  DIV_W  divide ratio d.
- cfg_en  input  1  1 = run channel, 0 = stop it.
- cfg_err  output  1  one-cycle pulse: accepted request had cfg_ch >= NUM_CH.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle pulse coincident with each clk_out rising cycle.
- busy  output  NUM_CH  channel holds a pending, not-yet-applied config.

## Operation
- Per-channel state: IDLE (stopped, clk_out=0), RUN, PEND (running, new config latched).
- Ratio coercion: cfg_div < 2 is treated as 2. No bypass mode.
- Per-channel registers:
  - div: active ratio; reset value 2.
  - cnt: 0..div-1.
  - hi = ceil(div/2).
- RUN/PEND waveform: clk_out=1 while cnt < hi, else 0. tick=1 when cnt==0. cnt wraps at div-1 to 0.
- cfg_ready = 1 when cfg_ch >= NUM_CH or busy[cfg_ch]==0. Otherwise 0.
- Out-of-range channel: request is accepted, dropped, and cfg_err pulses.
- Accept while IDLE:
  - div = coerced d.
  - If cfg_en: cnt=0, clk_out=1, tick=1 from the next cycle; state RUN.
  - If !cfg_en: only div is updated; state stays IDLE.
- Accept while RUN: store pend_div/pend_en; state PEND; busy=1.
- Boundary in PEND (cnt==div-1):
  - At that edge: div=pend_div, cnt=0, busy=0.
  - If pend_en: clk_out=1, tick=1, state RUN.
  - If !pend_en: clk_out=0, state IDLE.
  - Stopping never truncates a high phase.
- Channels are fully independent. Only one config is accepted per cycle.

## Timing
- Reset: all outputs are 0, states are IDLE, div=2, cnt=0. Reset asserted mid-period forces clk_out low immediately and discards any pending config.
- Start latency: accepted at edge k (IDLE, en=1) → clk_out and tick high during cycle k+1.
- Ratio-change latency: from acceptance to the end of the current period, at most div cycles. The old waveform completes unchanged.
- Acceptance at the same edge as the boundary cycle (cnt==div-1, RUN): the request goes to PEND and applies at the next boundary, not this one.
- busy rises the cycle after acceptance and falls the cycle after the applying edge. cfg_ready for that channel is low throughout.
- Reference waveforms:
  - d=4: clk_out 1,1,0,0.
  - d=3: 1,1,0.
  - d=2: 1,0.
  - tick high only on the first 1 of each period.

## Structure
- Package clk_div_pkg:
  - ch_state_e {IDLE, RUN, PEND}.
  - MIN_DIV=2.
  - Function hi_count(d) returning ceil(d/2).
- Sub-module clk_div_chan: one channel holding state, counter, pending registers and waveform decode. Instantiated NUM_CH times by a generate loop.
- Top-level logic: config decode, cfg_ready mux, cfg_err generation.

## Test plan
- Reset, then cfg ch0 d=4 en=1 → clk_out[0] pattern 1,1,0,0 repeating from the cycle after acceptance; tick[0] every 4th cycle; clk_out[1] stays 0.
- ch0 running d=4, cfg d=3 accepted at cnt=1 → busy=1, current 4-cycle period completes, then 1,1,0 pattern; busy clears at the boundary.
- ch1 running d=5, cfg en=0 → clk_out[1] finishes 1,1,1,0,0 then holds 0, state IDLE; no glitch or short pulse.
- While ch0 busy, cfg_valid to ch0 → cfg_ready=0 until the boundary. A cfg to ch1 in the same cycle → accepted.
- cfg_div=0 and cfg_div=1 → behave as d=2 (1,0). cfg_ch=NUM_CH → cfg_err pulse, no channel change.
- Assert rst_n low mid high-phase on both channels → all clk_out, tick and busy go to 0 asynchronously; after release the channels stay idle until reconfigured.

Source files
------------

// File: rtl/clk_div_pkg.sv
// ==== clk_div_pkg : shared types, constants and helpers for the clock divider bank -- rev 1.0 ====
`default_nettype none

package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ch_state_e;

  localparam int MIN_DIV = 2;

  // Length of the high phase: ceil(d/2), so odd ratios run one cycle longer high.
  function automatic int unsigned hi_count(input int unsigned d);
    return (d + 32'd1) / 32'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_bank_if.sv
// ==== clk_div_bank_if : runtime configuration port of the clock divider bank -- rev 1.0 ====
`default_nettype none

interface clk_div_bank_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, cfg_err
  );

endinterface

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ==== clk_div_chan : one divider channel holding state, counter, pending config and waveform decode -- rev 1.0 ====
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             load_en,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);

  ch_state_e        state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;
  logic             pend_en;

  logic [DIV_W-1:0] d_coerced;
  logic [DIV_W-1:0] cnt_next;
  logic             wrap;
  logic             next_high;

  always_comb begin
    d_coerced = (load_div < MIN_D) ? MIN_D : load_div;
    wrap      = (cnt == (div - 1'b1));
    cnt_next  = wrap ? '0 : (cnt + 1'b1);
    next_high = (32'(cnt_next) < hi_count(32'(div)));
  end

  assign busy = (state == PEND);

  // clk_out/tick are registered from the counter value they will show next cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= MIN_D;
      cnt      <= '0;
      pend_div <= MIN_D;
      pend_en  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          tick    <= 1'b0;
          cnt     <= '0;
          if (load) begin
            div <= d_coerced;
            if (load_en) begin
              clk_out <= 1'b1;
              tick    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          cnt     <= cnt_next;
          clk_out <= next_high;
          tick    <= wrap;
          if (load) begin
            pend_div <= d_coerced;
            pend_en  <= load_en;
            state    <= PEND;
          end
        end
        PEND: begin
          if (wrap) begin
            div     <= pend_div;
            cnt     <= '0;
            clk_out <= pend_en;
            tick    <= pend_en;
            state   <= pend_en ? RUN : IDLE;
          end else begin
            cnt     <= cnt_next;
            clk_out <= next_high;
            tick    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
// ==== clk_div_bank : bank of runtime-programmable glitch-free clock dividers -- rev 1.0 ====
`default_nettype none

module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              in_range;
  logic              sel_busy;
  logic              accept;
  logic [NUM_CH-1:0] load;

  // Decode by comparison loop so out-of-range selects never index the busy vector.
  always_comb begin
    in_range = 1'b0;
    sel_busy = 1'b0;
    load     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        in_range = 1'b1;
        sel_busy = busy[i];
        load[i]  = accept;
      end
    end
  end

  assign cfg.cfg_ready = !in_range || !sel_busy;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= accept && !in_range;
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      clk_div_chan #(
        .DIV_W (DIV_W)
      ) u_chan (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (load[g]),
        .load_div (cfg.cfg_div),
        .load_en  (cfg.cfg_en),
        .clk_out  (clk_out[g]),
        .tick     (tick[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ==== tb_clk_div_bank : directed self-checking bench for clk_div_bank -- rev 1.0 ====
`default_nettype none

module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clk_div_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .cfg     (bus),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  task automatic apply_reset();
    bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  // Presents one request at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cfg(input logic [1:0] ch, input logic [DIV_W-1:0] d, input logic en);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = ch;
    bus.cfg_div   = d;
    bus.cfg_en    = en;
    @(negedge clk_in);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    tests++;
    if (clk_out !== 3'b000 || tick !== 3'b000 || busy !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got clk=%b tick=%b busy=%b want all 000", clk_out, tick, busy);
    end
    tests++;
    if (bus.cfg_err !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_cfg: got err=%b ready=%b want err=0 ready=1", bus.cfg_err, bus.cfg_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    logic [7:0] exp_clk;
    logic [7:0] exp_tick;
    exp_clk  = 8'b0011_0011;
    exp_tick = 8'b0001_0001;
    apply_reset();
    send_cfg(2'd0, 8'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (clk_out[0] !== exp_clk[i] || tick[0] !== exp_tick[i] || clk_out[2:1] !== 2'b00) begin
        fails++;
        $display("FAIL start_d4 cyc %0d: got clk=%b tick=%b want clk0=%b tick0=%b others 0",
                 i, clk_out, tick, exp_clk[i], exp_tick[i]);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_change();
    logic [7:0] exp_clk;
    logic [7:0] exp_tick;
    logic [7:0] exp_busy;
    exp_clk  = 8'b0110_1100;
    exp_tick = 8'b0010_0100;
    exp_busy = 8'b0000_0011;
    apply_reset();
    send_cfg(2'd0, 8'd4, 1'b1);
    @(negedge clk_in);
    send_cfg(2'd0, 8'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (clk_out[0] !== exp_clk[i] || tick[0] !== exp_tick[i] || busy[0] !== exp_busy[i]) begin
        fails++;
        $display("FAIL change_4to3 cyc %0d: got clk0=%b tick0=%b busy0=%b want %b %b %b",
                 i, clk_out[0], tick[0], busy[0], exp_clk[i], exp_tick[i], exp_busy[i]);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_stop();
    logic [5:0] exp_clk;
    logic [5:0] exp_busy;
    exp_clk  = 6'b00_0001;
    exp_busy = 6'b00_0111;
    apply_reset();
    send_cfg(2'd1, 8'd5, 1'b1);
    @(negedge clk_in);
    send_cfg(2'd1, 8'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (clk_out[1] !== exp_clk[i] || busy[1] !== exp_busy[i] || tick[1] !== 1'b0 || clk_out[0] !== 1'b0) begin
        fails++;
        $display("FAIL stop_d5 cyc %0d: got clk=%b tick=%b busy1=%b want clk1=%b busy1=%b tick1=0",
                 i, clk_out, tick, busy[1], exp_clk[i], exp_busy[i]);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_busy_ready();
    apply_reset();
    send_cfg(2'd0, 8'd6, 1'b1);
    send_cfg(2'd0, 8'd2, 1'b1);
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL busy_rise: got busy0=%b want 1", busy[0]);
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'd0;
    bus.cfg_div   = 8'd4;
    bus.cfg_en    = 1'b1;
    #1;
    tests++;
    if (bus.cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_busy_a: got ready=%b want 0", bus.cfg_ready);
    end
    @(negedge clk_in);
    tests++;
    if (bus.cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_busy_b: got ready=%b want 0", bus.cfg_ready);
    end
    bus.cfg_ch  = 2'd1;
    bus.cfg_div = 8'd3;
    #1;
    tests++;
    if (bus.cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_other_ch: got ready=%b want 1", bus.cfg_ready);
    end
    @(negedge clk_in);
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = 2'd0;
    tests++;
    if (clk_out[1] !== 1'b1 || tick[1] !== 1'b1 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL other_ch_start: got clk1=%b tick1=%b busy0=%b want 1 1 1", clk_out[1], tick[1], busy[0]);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    tests++;
    if (busy[0] !== 1'b1 || bus.cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_hold: got busy0=%b ready=%b want 1 0", busy[0], bus.cfg_ready);
    end
    @(negedge clk_in);
    tests++;
    if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1 || busy[0] !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL busy_apply: got clk0=%b tick0=%b busy0=%b ready=%b want 1 1 0 1",
               clk_out[0], tick[0], busy[0], bus.cfg_ready);
    end
    @(negedge clk_in);
    tests++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
      fails++;
      $display("FAIL blocked_cfg_dropped_a: got clk0=%b tick0=%b want 0 0", clk_out[0], tick[0]);
    end
    @(negedge clk_in);
    tests++;
    if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
      fails++;
      $display("FAIL blocked_cfg_dropped_b: got clk0=%b tick0=%b want 1 1", clk_out[0], tick[0]);
    end
  endtask

  task automatic test_coerce();
    logic [3:0] exp_pat;
    exp_pat = 4'b0101;
    apply_reset();
    send_cfg(2'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (clk_out[0] !== exp_pat[i] || tick[0] !== exp_pat[i]) begin
        fails++;
        $display("FAIL coerce_d0 cyc %0d: got clk0=%b tick0=%b want %b", i, clk_out[0], tick[0], exp_pat[i]);
      end
      @(negedge clk_in);
    end
    send_cfg(2'd1, 8'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (clk_out[1] !== exp_pat[i] || tick[1] !== exp_pat[i]) begin
        fails++;
        $display("FAIL coerce_d1 cyc %0d: got clk1=%b tick1=%b want %b", i, clk_out[1], tick[1], exp_pat[i]);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'd3;
    bus.cfg_div   = 8'd5;
    bus.cfg_en    = 1'b1;
    #1;
    tests++;
    if (bus.cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL oor_ready: got ready=%b want 1", bus.cfg_ready);
    end
    @(negedge clk_in);
    bus.cfg_valid = 1'b0;
    tests++;
    if (bus.cfg_err !== 1'b1 || clk_out !== 3'b000 || busy !== 3'b000) begin
      fails++;
      $display("FAIL oor_err: got err=%b clk=%b busy=%b want 1 000 000", bus.cfg_err, clk_out, busy);
    end
    @(negedge clk_in);
    tests++;
    if (bus.cfg_err !== 1'b0 || clk_out !== 3'b000) begin
      fails++;
      $display("FAIL oor_pulse_end: got err=%b clk=%b want 0 000", bus.cfg_err, clk_out);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_cfg(2'd0, 8'd8, 1'b1);
    send_cfg(2'd1, 8'd6, 1'b1);
    send_cfg(2'd0, 8'd3, 1'b1);
    tests++;
    if (clk_out !== 3'b011 || busy !== 3'b001) begin
      fails++;
      $display("FAIL pre_reset: got clk=%b busy=%b want 011 001", clk_out, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (clk_out !== 3'b000 || tick !== 3'b000 || busy !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: got clk=%b tick=%b busy=%b want 000", clk_out, tick, busy);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      tests++;
      if (clk_out !== 3'b000 || busy !== 3'b000) begin
        fails++;
        $display("FAIL post_reset_idle cyc %0d: got clk=%b busy=%b want 000", i, clk_out, busy);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
    bus.cfg_en    = 1'b0;
    test_reset();
    test_start();
    test_change();
    test_stop();
    test_busy_ready();
    test_coerce();
    test_out_of_range();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
